context_pkt_parser: RTL

Receive-side decoder for the 36-bit fifo context packets produced by the TX chain's context packet generator (flow-control and error/ack reports). It sits at the host-facing end of the error/flow stream, or in loopback test benches. It consumes one packet at a time, checks its framing, extracts stream ID, VITA time, message and sequence number, and presents them as a single held result with a valid/ack handshake. Malformed packets are dropped and counted.

---
 rtl/context_pkt_parser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/context_pkt_parser.sv
// Receive-side decoder for fifo36 context packets: checks framing, extracts stream ID,
// VITA time, message and sequence number, and holds the result until acknowledged.
module context_pkt_parser #(
    parameter int PROT_ENG_FLAGS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [35:0] data_i,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic        pkt_valid_o,
    input  logic        pkt_ack_i,
    output logic [31:0] streamid_o,
    output logic [63:0] vita_time_o,
    output logic [31:0] message_o,
    output logic [31:0] seqnum_o,
    output logic [15:0] err_count_o
);

    // The optional PE word is consumed by whichever state sees its SOF, so HDR follows it directly.
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_SID, S_SECS, S_THI, S_TLO, S_MSG, S_SEQ, S_DRAIN, S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sid_q, secs_q, tlo_q, msg_q;
    logic [31:0] streamid_q, message_q, seqnum_q;
    logic [63:0] vita_q;
    logic [15:0] err_q;

    logic [31:0] payload;
    logic        sof, eof, xfer, hdr_ok;
    logic        err_evt, load_out;
    state_t      start_state;
    logic        start_err;
    logic        occ_unused;

    assign payload    = data_i[31:0];
    assign sof        = data_i[32];
    assign eof        = data_i[33];
    assign occ_unused = ^data_i[35:34];
    assign hdr_ok     = (payload[31:28] == 4'h4) && (payload[15:0] == 16'd7);
    assign dst_rdy_o  = (state_q != S_HOLD);
    assign xfer       = src_rdy_i & dst_rdy_o;

    // Outcome of a SOF word, shared by IDLE and by a mid-packet restart.
    always_comb begin
        start_state = S_SID;
        start_err   = 1'b0;
        if (PROT_ENG_FLAGS != 0) begin
            start_state = S_HDR;
        end else if (eof) begin
            start_state = S_IDLE;
            start_err   = 1'b1;
        end else if (!hdr_ok) begin
            start_state = S_DRAIN;
            start_err   = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_evt  = 1'b0;
        load_out = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer && sof) begin
                        state_d = start_state;
                        err_evt = start_err;
                    end
                end
                S_HOLD: begin
                    if (pkt_ack_i) state_d = S_IDLE;
                end
                S_DRAIN: begin
                    if (xfer && eof) state_d = S_IDLE;
                end
                default: begin
                    if (xfer) begin
                        if (sof) begin
                            state_d = start_state;
                            err_evt = 1'b1;
                        end else if (eof && state_q != S_SEQ) begin
                            state_d = S_IDLE;
                            err_evt = 1'b1;
                        end else begin
                            case (state_q)
                                S_HDR: begin
                                    state_d = hdr_ok ? S_SID : S_DRAIN;
                                    err_evt = !hdr_ok;
                                end
                                S_SID:  state_d = S_SECS;
                                S_SECS: state_d = S_THI;
                                S_THI: begin
                                    state_d = (payload == 32'd0) ? S_TLO : S_DRAIN;
                                    err_evt = (payload != 32'd0);
                                end
                                S_TLO:  state_d = S_MSG;
                                S_MSG:  state_d = S_SEQ;
                                S_SEQ: begin
                                    if (eof) begin
                                        state_d  = S_HOLD;
                                        load_out = 1'b1;
                                    end else begin
                                        state_d = S_DRAIN;
                                        err_evt = 1'b1;
                                    end
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sid_q      <= '0;
            secs_q     <= '0;
            tlo_q      <= '0;
            msg_q      <= '0;
            streamid_q <= '0;
            vita_q     <= '0;
            message_q  <= '0;
            seqnum_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                case (state_q)
                    S_SID:   sid_q  <= payload;
                    S_SECS:  secs_q <= payload;
                    S_TLO:   tlo_q  <= payload;
                    S_MSG:   msg_q  <= payload;
                    default: ;
                endcase
            end
            // Published fields move only when a complete packet enters HOLD.
            if (load_out) begin
                streamid_q <= sid_q;
                vita_q     <= {secs_q, tlo_q};
                message_q  <= msg_q;
                seqnum_q   <= payload;
            end
            if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end

    assign pkt_valid_o = (state_q == S_HOLD);
    assign streamid_o  = streamid_q;
    assign vita_time_o = vita_q;
    assign message_o   = message_q;
    assign seqnum_o    = seqnum_q;
    assign err_count_o = err_q;

endmodule
